// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-synapse datapath.
package snn_pkg;

    localparam int unsigned SNN_WIDTH       = 8;
    localparam int unsigned SNN_DELAY_DEPTH = 8;
    localparam int unsigned SNN_DSEL_W      = 3;
    localparam int unsigned DECAY_W         = 2;
    localparam int unsigned SHIFT_W         = 3;
    localparam int unsigned CUR_MAX         = (1 << SNN_WIDTH) - 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } syn_state_t;

    // Decay select encodes a right shift of sel+1 (1..4).
    function automatic logic [SHIFT_W-1:0] decay_shift(input logic [DECAY_W-1:0] sel);
        return SHIFT_W'(sel) + SHIFT_W'(1);
    endfunction

endpackage

// File: rtl/spike_delay_line.sv
// Axonal delay: shift register of sampled spikes with a selectable tap.
module spike_delay_line #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_in,
    input  logic [SEL_W-1:0] sel,
    output logic             tap_out,
    output logic             any_pending
);

    logic [DEPTH-1:0] dl;

    // Shift a new sample in at stage 0 every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl <= '0;
        end else begin
            dl <= {dl[DEPTH-2:0], spike_in};
        end
    end

    assign tap_out = dl[sel];

    // High when the line will still hold a spike after the coming edge.
    assign any_pending = spike_in | (|dl[DEPTH-2:0]);

endmodule

// File: rtl/spike_synapse.sv
// Spike-to-current synapse: delayed spikes add a weight into a leaky,
// saturating current register.
module spike_synapse
    import snn_pkg::*;
#(
    parameter int unsigned WIDTH       = SNN_WIDTH,
    parameter int unsigned DELAY_DEPTH = SNN_DELAY_DEPTH,
    parameter int unsigned DSEL_W      = SNN_DSEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spike_in,
    input  logic [WIDTH-1:0]  weight,
    input  logic [DSEL_W-1:0] delay_sel,
    input  logic [1:0]        decay_sel,
    input  logic              load_cfg,
    output logic [WIDTH-1:0]  current,
    output logic              busy
);

    logic [DSEL_W-1:0]  cfg_delay;
    logic [DECAY_W-1:0] cfg_decay;
    logic               ds;
    logic               pending;
    logic [WIDTH-1:0]   leak_c;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   current_nxt;
    syn_state_t         state_q;
    syn_state_t         state_nxt;

    spike_delay_line #(
        .DEPTH (DELAY_DEPTH),
        .SEL_W (DSEL_W)
    ) u_delay (
        .clk         (clk),
        .rst_n       (rst_n),
        .spike_in    (spike_in),
        .sel         (cfg_delay),
        .tap_out     (ds),
        .any_pending (pending)
    );

    // Config registers; the tap sees the old delay on the load edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_delay <= '0;
            cfg_decay <= '0;
        end else if (load_cfg) begin
            cfg_delay <= delay_sel;
            cfg_decay <= decay_sel;
        end
    end

    // Leak with a floor of 1 so current always drains to zero, then add and clip.
    always_comb begin
        leak_c = current >> decay_shift(cfg_decay);
        if (leak_c == '0 && current != '0) begin
            leak_c = WIDTH'(1);
        end
        sum_c = {1'b0, current} - {1'b0, leak_c} + (ds ? {1'b0, weight} : '0);
        current_nxt = sum_c[WIDTH] ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
    end

    // Current and state registers; busy mirrors the post-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current <= '0;
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            current <= current_nxt;
            state_q <= state_nxt;
            busy    <= (state_nxt == ACTIVE);
        end
    end

    // Activity FSM: ACTIVE while a spike is in flight or current is nonzero.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (pending || current != '0) state_nxt = ACTIVE;
            ACTIVE:  if (!pending && current_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule
